// File: rtl/bilbo_reg.sv
// BILBO register: NORMAL / SHIFT / MISR / SEED modes plus a self-timed MISR test session.
// Optional signature comparator is built only when BILBO_SIG_CMP_EN is defined.
module bilbo_reg #(
  parameter int unsigned          WIDTH = 8,
  parameter logic [WIDTH-1:0]     POLY  = 8'hB8,
  parameter logic [WIDTH-1:0]     SEED  = 8'h01,
  parameter int unsigned          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] si,
  input  logic             scan_in,
  input  logic             start,
  input  logic             ack,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [WIDTH-1:0] golden,
  output logic [WIDTH-1:0] so,
  output logic             scan_out,
  output logic             busy,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_NORMAL = 2'b00,
    M_SHIFT  = 2'b01,
    M_MISR   = 2'b10,
    M_SEED   = 2'b11
  } mode_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] r, r_nx, misr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             launch;

  // Galois step: shift left, fold POLY in when the MSB falls out, then absorb si.
  assign misr_nx = {r[WIDTH-2:0], 1'b0} ^ (r[WIDTH-1] ? POLY : '0) ^ si;

  // A session launches from IDLE on start, or from DONE on start without ack.
  assign launch = start && ((state == IDLE) || ((state == DONE) && !ack));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r   <= '0;
      cnt <= '0;
    end else begin
      r   <= r_nx;
      cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = (num_cycles != '0) ? RUN : DONE;
      RUN:     if (cnt == CNT_W'(1)) state_nx = DONE;
      DONE: begin
        if (ack)         state_nx = IDLE;
        else if (launch) state_nx = (num_cycles != '0) ? RUN : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    r_nx   = r;
    cnt_nx = cnt;
    if (launch) begin
      r_nx   = SEED;
      cnt_nx = num_cycles;
    end else begin
      case (state)
        IDLE: begin
          case (mode_t'(mode))
            M_NORMAL: r_nx = si;
            M_SHIFT:  r_nx = {r[WIDTH-2:0], scan_in};
            M_MISR:   r_nx = misr_nx;
            M_SEED:   r_nx = SEED;
            default:  r_nx = r;
          endcase
        end
        RUN: begin
          r_nx = misr_nx;
          // Counter parks at 1 on the final step rather than reaching zero.
          if (cnt != CNT_W'(1)) cnt_nx = cnt - CNT_W'(1);
        end
        default: r_nx = r;
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  assign so       = r;
  assign scan_out = r[WIDTH-1];

`ifdef BILBO_SIG_CMP_EN
  assign pass = done && (r == golden);
`else
  logic unused_golden;
  assign unused_golden = ^golden;
  assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_bilbo_reg.sv
// Self-checking bench for bilbo_reg: directed scenarios then randomized traffic
// compared against a cycle-level reference model kept in plain integer arithmetic.
module tb_bilbo_reg;

  localparam int POLY_I = 'hB8;
  localparam int SEED_I = 'h01;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  si = '0;
  logic        scan_in = 1'b0;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] num_cycles = '0;
  logic [7:0]  golden = '0;
  logic [7:0]  so;
  logic        scan_out, busy, done, pass;

  int checks = 0;
  int failures = 0;

  // reference model: register value, phase (0 idle, 1 session running, 2 finished), steps left
  int m_r = 0;
  int m_phase = 0;
  int m_left = 0;

  bilbo_reg #(.WIDTH(8), .POLY(8'hB8), .SEED(8'h01), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .si(si), .scan_in(scan_in),
    .start(start), .ack(ack), .num_cycles(num_cycles), .golden(golden),
    .so(so), .scan_out(scan_out), .busy(busy), .done(done), .pass(pass)
  );

  always #5 clk = ~clk;

  function automatic int misr_ref(input int x, input int d);
    int y;
    y = (x * 2) % 256;
    if (x >= 128) y = y ^ POLY_I;
    return y ^ d;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_pass;
    exp_pass = 0;
`ifdef BILBO_SIG_CMP_EN
    if (m_phase == 2 && m_r == int'(golden)) exp_pass = 1;
`endif
    check({tag, ".so"},       int'(so),       m_r);
    check({tag, ".scan_out"}, int'(scan_out), m_r / 128);
    check({tag, ".busy"},     int'(busy),     (m_phase == 1) ? 1 : 0);
    check({tag, ".done"},     int'(done),     (m_phase == 2) ? 1 : 0);
    check({tag, ".pass"},     int'(pass),     exp_pass);
  endtask

  task automatic model_launch();
    m_r = SEED_I;
    m_left = int'(num_cycles);
    m_phase = (m_left != 0) ? 1 : 2;
  endtask

  task automatic model_edge();
    case (m_phase)
      0: begin
        if (start) model_launch();
        else case (mode)
          2'b00: m_r = int'(si);
          2'b01: m_r = ((m_r * 2) % 256) + int'(scan_in);
          2'b10: m_r = misr_ref(m_r, int'(si));
          default: m_r = SEED_I;
        endcase
      end
      1: begin
        m_r = misr_ref(m_r, int'(si));
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
      default: begin
        if (ack) m_phase = 0;
        else if (start) model_launch();
      end
    endcase
  endtask

  // one clock edge: model advances with the inputs the DUT sees, outputs sampled 1 time unit later
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; ack = 0; mode = 2'b00; si = '0; scan_in = 0;
  endtask

  initial begin
    int bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int exp_v;

    // reset state
    #2;
    check_all("reset");
    @(negedge clk);
    rst = 1;

    // 1. NORMAL then SEED
    mode = 2'b00; si = 8'hA5; step();
    check_all("t1.normal");
    check("t1.normal_val", int'(so), 'hA5);
    mode = 2'b11; si = 8'h5A; step();
    check("t1.seed_val", int'(so), 'h01);

    // 2. SHIFT pattern from zero
    mode = 2'b00; si = '0; step();
    mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      scan_in = bits[i][0];
      step();
      check_all("t2.shift");
    end
    check("t2.shift_val", int'(so), 'hB2);

    // 3. eight-step PRPG session
    idle_inputs(); si = '0; num_cycles = 16'd8; golden = 8'hB8; start = 1; step();
    start = 0;
    check("t3.launch_busy", int'(busy), 1);
    check("t3.launch_so", int'(so), 'h01);
    exp_v = 2;
    for (int i = 0; i < 8; i++) begin
      step();
      check_all("t3.run");
      if (i < 7) begin
        check("t3.seq", int'(so), exp_v);
        exp_v = exp_v * 2;
      end
    end
    check("t3.final_so", int'(so), 'hB8);
    check("t3.done", int'(done), 1);
`ifdef BILBO_SIG_CMP_EN
    check("t3.pass_hi", int'(pass), 1);
`else
    check("t3.pass_off", int'(pass), 0);
`endif
    golden = 8'hB9; #1;
    check("t3.pass_lo", int'(pass), 0);
    check_all("t3.golden_b9");
    ack = 1; step(); ack = 0;
    check_all("t3.ack");

    // 4. zero-length session
    num_cycles = 16'd0; start = 1; step(); start = 0;
    check_all("t4.zero");
    check("t4.done", int'(done), 1);
    check("t4.so", int'(so), 'h01);

    // 5. ack beats start, then start alone relaunches from DONE
    start = 1; ack = 1; num_cycles = 16'd3; step(); start = 0; ack = 0;
    check("t5.ack_wins", int'(done), 0);
    check_all("t5.ack_wins_all");
    num_cycles = 16'd0; start = 1; step(); start = 0;
    check("t5.redone", int'(done), 1);
    num_cycles = 16'd3; start = 1; si = 8'h77; step(); start = 0;
    check("t5.relaunch_busy", int'(busy), 1);
    check("t5.relaunch_so", int'(so), 'h01);
    check_all("t5.relaunch");
    for (int i = 0; i < 3; i++) begin si = 8'($urandom); step(); check_all("t5.run"); end

    // 6. asynchronous reset mid-session
    ack = 1; step(); ack = 0;
    num_cycles = 16'd10; si = '0; start = 1; step(); start = 0;
    step(); step();
    check("t6.running", int'(busy), 1);
    #2 rst = 0; #1;
    m_r = 0; m_phase = 0; m_left = 0;
    check_all("t6.async_rst");
    @(negedge clk); rst = 1;
    mode = 2'b00; si = 8'h3C; step();
    check("t6.after_rst", int'(so), 'h3C);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      mode = 2'($urandom);
      si = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      scan_in = 1'($urandom);
      start = ($urandom_range(0, 7) == 0);
      ack = ($urandom_range(0, 3) == 0);
      num_cycles = 16'($urandom_range(0, 12));
      if (m_phase != 2) golden = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'(m_r);
      step();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
